// File: rtl/io_cond_pkg.sv
// -----------------------------------------------------------------------------
// io_cond_pkg
// Shared constants and helpers for the input conditioning stage.
//   NUM_SW_DEF / NUM_BTN_DEF : default board pin counts
//   DEBOUNCE_50MHZ_20MS      : 20 ms settle time at a 50 MHz core clock
//   cnt_width(n)             : bits needed to hold a debounce count up to n
// -----------------------------------------------------------------------------
package io_cond_pkg;

    localparam int NUM_SW_DEF          = 9;
    localparam int NUM_BTN_DEF         = 4;
    localparam int DEBOUNCE_50MHZ_20MS = 1_000_000;

    function automatic int cnt_width(input int n);
        int w;
        w = $clog2(n + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// -----------------------------------------------------------------------------
// debounce_bit
// One input bit: 2-FF synchronizer, debounce counter and stable level.
// Ports:
//   clk_i   : core clock, rising edge
//   rst_ni  : asynchronous active-low reset
//   async_i : raw pin, asynchronous to clk_i
//   stb_o   : debounced level (after optional inversion), active-high
// Parameters:
//   DEBOUNCE_CYCLES : consecutive differing cycles needed to accept a level
//   SYNC_RST_VAL    : synchronizer reset value (idle pin level)
//   INVERT          : invert the synchronized value before debouncing
// -----------------------------------------------------------------------------
module debounce_bit
    import io_cond_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = DEBOUNCE_50MHZ_20MS,
    parameter logic SYNC_RST_VAL    = 1'b0,
    parameter logic INVERT          = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic stb_o
);

    localparam int              CW   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   TERM = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic [CW-1:0] r_cnt;
    logic          r_stb;
    logic          w_sync;

    // Polarity is applied after the synchronizer so the sync FFs keep the
    // raw idle pin level as their reset value.
    assign w_sync = r_sync2 ^ INVERT;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sync1 <= SYNC_RST_VAL;
            r_sync2 <= SYNC_RST_VAL;
            r_cnt   <= '0;
            r_stb   <= 1'b0;
        end else begin
            r_sync1 <= async_i;
            r_sync2 <= r_sync1;
            if (w_sync == r_stb) begin
                // Any return to the accepted level discards the partial count.
                r_cnt <= '0;
            end else if (r_cnt == TERM) begin
                r_stb <= w_sync;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign stb_o = r_stb;

endmodule

// File: rtl/io_input_conditioner.sv
// -----------------------------------------------------------------------------
// io_input_conditioner
// Synchronizes and debounces slide switches and push buttons for the core.
// Ports:
//   clk_i         : core clock, rising edge
//   rst_ni        : asynchronous active-low reset
//   sw_async_i    : raw switch pins, active-high
//   btn_async_i   : raw KEY pins, active-low (0 = pressed)
//   btn_evt_clr_i : clears the matching sticky press flag
//   sw_o          : debounced switch levels
//   btn_o         : debounced button levels, active-high
//   btn_press_o   : one-cycle pulse on each debounced press
//   btn_evt_o     : sticky "pressed since last clear" flags
// All outputs are registered.
// -----------------------------------------------------------------------------
module io_input_conditioner
    import io_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_50MHZ_20MS,
    parameter int NUM_SW          = NUM_SW_DEF,
    parameter int NUM_BTN         = NUM_BTN_DEF
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NUM_SW-1:0]  sw_async_i,
    input  logic [NUM_BTN-1:0] btn_async_i,
    input  logic [NUM_BTN-1:0] btn_evt_clr_i,
    output logic [NUM_SW-1:0]  sw_o,
    output logic [NUM_BTN-1:0] btn_o,
    output logic [NUM_BTN-1:0] btn_press_o,
    output logic [NUM_BTN-1:0] btn_evt_o
);

    logic [NUM_SW-1:0]  w_sw_stb;
    logic [NUM_BTN-1:0] w_btn_stb;

    logic [NUM_SW-1:0]  r_sw;
    logic [NUM_BTN-1:0] r_btn;
    logic [NUM_BTN-1:0] r_press;
    logic [NUM_BTN-1:0] r_evt;

    for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .SYNC_RST_VAL    (1'b0),
            .INVERT          (1'b0)
        ) u_db (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .async_i (sw_async_i[i]),
            .stb_o   (w_sw_stb[i])
        );
    end

    // KEY pins idle high; inverted after the synchronizer so the stable level
    // and everything downstream is active-high.
    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .SYNC_RST_VAL    (1'b1),
            .INVERT          (1'b1)
        ) u_db (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .async_i (btn_async_i[i]),
            .stb_o   (w_btn_stb[i])
        );
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sw    <= '0;
            r_btn   <= '0;
            r_press <= '0;
            r_evt   <= '0;
        end else begin
            r_sw    <= w_sw_stb;
            r_btn   <= w_btn_stb;
            // r_btn is the previous stable level, so the pulse lines up with
            // the edge where btn_o rises.
            r_press <= w_btn_stb & ~r_btn;
            // Set has priority over clear so a press is never lost.
            r_evt   <= (r_evt & ~btn_evt_clr_i) | r_press;
        end
    end

    assign sw_o        = r_sw;
    assign btn_o       = r_btn;
    assign btn_press_o = r_press;
    assign btn_evt_o   = r_evt;

endmodule
